popcount_accumulator: RTL and testbench

- Sequential stage directly downstream of the 10-bit compressor adder tree in the XNOR/binary CNN datapath.
- Each beat consumes one 4-bit partial popcount (0..10). Beats are summed across a window that the producer delimits with in_last.
- At window end, emits the total, a beat count, saturation/range flags and a thresholded binary activation over a valid/ready handshake.

---
 rtl/npu_pkg.sv | 15 +
 rtl/popcount_accumulator_sat_add.sv | 23 ++
 rtl/popcount_accumulator.sv | 150 +++++++++++++++
 tb/tb_popcount_accumulator.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared constants and types for the binary CNN datapath.
// Widths of the popcount path and the accumulator FSM state.
package npu_pkg;

  localparam int CNT_W   = 4;
  localparam int ACC_W   = 12;
  localparam int BEATS_W = 8;
  localparam int MAX_CNT = 10;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/popcount_accumulator_sat_add.sv
// Saturating unsigned adder: sum = min(a + zext(b), 2^A_W-1).
// Ports: a, b operands; sum clamped result; ovf set when clamped.
module sat_add #(
  parameter int A_W = 12,
  parameter int B_W = 4
) (
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [A_W-1:0] sum,
  output logic           ovf
);

  localparam int PAD = A_W + 1 - B_W;

  logic [A_W:0] full;

  always_comb begin
    full = {1'b0, a} + {{PAD{1'b0}}, b};
    ovf  = full[A_W];
    sum  = ovf ? {A_W{1'b1}} : full[A_W-1:0];
  end

endmodule

// File: rtl/popcount_accumulator.sv
// Sums partial popcounts over a producer-delimited window and emits
// total, beat count, sat/range flags and activation via valid/ready.
module popcount_accumulator
  import npu_pkg::*;
#(
  parameter int CNT_W   = npu_pkg::CNT_W,
  parameter int ACC_W   = npu_pkg::ACC_W,
  parameter int BEATS_W = npu_pkg::BEATS_W,
  parameter int MAX_CNT = npu_pkg::MAX_CNT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CNT_W-1:0]   in_count,
  input  logic               in_last,
  input  logic [ACC_W-1:0]   cfg_thresh,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [BEATS_W-1:0] out_beats,
  output logic               out_act,
  output logic               out_sat,
  output logic               out_range_err
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CNT);

  state_t state;
  state_t state_nxt;

  logic               first;
  logic [ACC_W-1:0]   acc;
  logic [BEATS_W-1:0] beats;
  logic               sat_r;
  logic               rng_r;

  logic               accept;
  logic               xfer;

  logic [ACC_W-1:0]   acc_base;
  logic [BEATS_W-1:0] beats_base;
  logic [ACC_W-1:0]   acc_next;
  logic [BEATS_W-1:0] beats_next;
  logic               acc_ovf;
  logic               beats_ovf;
  logic               sat_next;
  logic               rng_next;

  // A new window ignores whatever the previous one left behind.
  always_comb begin
    acc_base   = first ? '0 : acc;
    beats_base = first ? '0 : beats;
  end

  sat_add #(
    .A_W (ACC_W),
    .B_W (CNT_W)
  ) u_acc_add (
    .a   (acc_base),
    .b   (in_count),
    .sum (acc_next),
    .ovf (acc_ovf)
  );

  sat_add #(
    .A_W (BEATS_W),
    .B_W (1)
  ) u_beats_add (
    .a   (beats_base),
    .b   (1'b1),
    .sum (beats_next),
    .ovf (beats_ovf)
  );

  always_comb begin
    sat_next = (!first && sat_r)
             | acc_ovf
             | beats_ovf;
    rng_next = (!first && rng_r)
             | (in_count > MAX_V);
  end

  always_comb begin
    out_valid = (state == HOLD);
    in_ready  = !out_valid || out_ready;
    accept    = in_valid && in_ready;
    xfer      = out_valid && out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACCUM: begin
        if (accept && in_last) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (xfer && !(accept && in_last)) begin
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first <= 1'b1;
      acc   <= '0;
      beats <= '0;
      sat_r <= 1'b0;
      rng_r <= 1'b0;
    end else if (accept) begin
      first <= in_last;
      acc   <= acc_next;
      beats <= beats_next;
      sat_r <= sat_next;
      rng_r <= rng_next;
    end
  end

  // Result registers only move on a last beat, so they stay
  // stable across any stall in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum       <= '0;
      out_beats     <= '0;
      out_act       <= 1'b0;
      out_sat       <= 1'b0;
      out_range_err <= 1'b0;
    end else if (accept && in_last) begin
      out_sum       <= acc_next;
      out_beats     <= beats_next;
      out_act       <= (acc_next >= cfg_thresh);
      out_sat       <= sat_next;
      out_range_err <= rng_next;
    end
  end

endmodule

// File: tb/tb_popcount_accumulator.sv
// Randomized + directed bench for popcount_accumulator.
// Window totals modelled with unbounded integers, clamped at emit.
module tb_popcount_accumulator;

  localparam int ACC_W   = 12;
  localparam int BEATS_W = 8;
  localparam int ACC_MAX = (1 << ACC_W) - 1;
  localparam int BT_MAX  = (1 << BEATS_W) - 1;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         in_count;
  logic               in_last;
  logic [ACC_W-1:0]   cfg_thresh;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_sum;
  logic [BEATS_W-1:0] out_beats;
  logic               out_act;
  logic               out_sat;
  logic               out_range_err;

  popcount_accumulator dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_count      (in_count),
    .in_last       (in_last),
    .cfg_thresh    (cfg_thresh),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sum       (out_sum),
    .out_beats     (out_beats),
    .out_act       (out_act),
    .out_sat       (out_sat),
    .out_range_err (out_range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  // window in progress
  int w_sum;
  int w_beats;
  bit w_rng;
  // held result
  bit m_valid;
  int m_sum;
  int m_beats;
  bit m_act;
  bit m_sat;
  bit m_rng;

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic model_clear();
    w_sum   = 0;
    w_beats = 0;
    w_rng   = 0;
    m_valid = 0;
    m_sum   = 0;
    m_beats = 0;
    m_act   = 0;
    m_sat   = 0;
    m_rng   = 0;
  endtask

  // Drive one cycle at posedge+1, check at negedge,
  // advance the model to the next edge.
  task automatic cyc(input bit v, input int c,
                     input bit l, input int t,
                     input bit r);
    bit rdy;
    bit acc;
    in_valid   = v;
    in_count   = 4'(c);
    in_last    = l;
    cfg_thresh = ACC_W'(t);
    out_ready  = r;
    #4;
    rdy = !m_valid || r;
    chk("in_ready", int'(in_ready), int'(rdy));
    chk("out_valid", int'(out_valid), int'(m_valid));
    if (m_valid) begin
      chk("out_sum", int'(out_sum), m_sum);
      chk("out_beats", int'(out_beats), m_beats);
      chk("out_act", int'(out_act), int'(m_act));
      chk("out_sat", int'(out_sat), int'(m_sat));
      chk("out_rng", int'(out_range_err), int'(m_rng));
    end
    acc = v && rdy;
    if (m_valid && r) m_valid = 0;
    if (acc) begin
      w_sum   += c;
      w_beats += 1;
      w_rng   |= (c > 10);
      if (l) begin
        m_valid = 1;
        m_sum   = (w_sum > ACC_MAX) ? ACC_MAX : w_sum;
        m_beats = (w_beats > BT_MAX) ? BT_MAX : w_beats;
        m_sat   = (w_sum > ACC_MAX) || (w_beats > BT_MAX);
        m_rng   = w_rng;
        m_act   = (m_sum >= t);
        w_sum   = 0;
        w_beats = 0;
        w_rng   = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1);
  endtask

  task automatic reset_dut();
    #2;
    rst_n = 1'b0;
    in_valid = 0;
    in_count = 0;
    in_last = 0;
    out_ready = 0;
    cfg_thresh = 0;
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sum", int'(out_sum), 0);
    chk("rst_beats", int'(out_beats), 0);
    chk("rst_act", int'(out_act), 0);
    chk("rst_sat", int'(out_sat), 0);
    chk("rst_rng", int'(out_range_err), 0);
    model_clear();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    reset_dut();

    // 3,7,10 -> 20
    cyc(1, 3, 0, 15, 1);
    cyc(1, 7, 0, 15, 1);
    cyc(1, 10, 1, 15, 1);
    chk("w1_sum", int'(out_sum), 20);
    chk("w1_beats", int'(out_beats), 3);
    chk("w1_act", int'(out_act), 1);
    idle(1);

    // single beat of 4 under threshold 5
    cyc(1, 4, 1, 5, 1);
    chk("w2_sum", int'(out_sum), 4);
    chk("w2_beats", int'(out_beats), 1);
    chk("w2_act", int'(out_act), 0);

    // 10 x5 with threshold equal to the total
    for (int i = 0; i < 5; i++) cyc(1, 10, i == 4, 50, 1);
    chk("w3_sum", int'(out_sum), 50);
    chk("w3_act", int'(out_act), 1);
    idle(1);

    // backpressure then same-cycle drain + new window
    cyc(1, 2, 0, 0, 0);
    cyc(1, 5, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 1, 0, 0);
      chk("bp_ready", int'(in_ready), 0);
      chk("bp_sum", int'(out_sum), 7);
    end
    cyc(1, 9, 1, 0, 1);
    chk("dr_valid", int'(out_valid), 1);
    chk("dr_sum", int'(out_sum), 9);
    chk("dr_beats", int'(out_beats), 1);
    idle(1);

    // out-of-range value is added, flagged
    cyc(1, 12, 0, 0, 1);
    cyc(1, 3, 1, 0, 1);
    chk("rg_sum", int'(out_sum), 15);
    chk("rg_flag", int'(out_range_err), 1);
    idle(1);

    // accumulator and beat counter both clamp
    for (int i = 0; i < 420; i++)
      cyc(1, 10, i == 419, 0, 1);
    chk("st_sum", int'(out_sum), ACC_MAX);
    chk("st_beats", int'(out_beats), BT_MAX);
    chk("st_sat", int'(out_sat), 1);
    cyc(1, 1, 1, 0, 1);
    chk("st_clr", int'(out_sat), 0);
    idle(1);

    // reset mid-window discards partial sums
    cyc(1, 6, 0, 0, 1);
    cyc(1, 6, 0, 0, 1);
    reset_dut();
    cyc(1, 1, 0, 0, 1);
    cyc(1, 2, 1, 0, 1);
    chk("rs_sum", int'(out_sum), 3);
    chk("rs_beats", int'(out_beats), 2);
    idle(1);

    // reset while a result is held
    cyc(1, 8, 1, 0, 0);
    reset_dut();
    idle(2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int c;
      c = ($urandom_range(0, 19) == 0)
        ? int'($urandom_range(11, 15))
        : int'($urandom_range(0, 10));
      cyc($urandom_range(0, 3) != 0, c,
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 60),
          $urandom_range(0, 9) < 7);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
